pl_frame_sequencer: RTL

Parametrised PL-frame symbol sequencer for the DVB-S2 modulator path. It emits one symbol per symbol strobe from a free-running clock-enable divider; no derived clocks are used. Each frame is a PLHEADER, then a slotted data payload, then optional pilot blocks. Payload bits arrive as bytes over a valid/ready handshake; the output feeds the scrambler/mapper and then the IQ FIR.

---
 rtl/dvbs2_pkg.sv | 31 +++
 rtl/pl_frame_sequencer_bit_repacker.sv | 64 ++++++
 rtl/pl_frame_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dvbs2_pkg.sv
// Shared types and DVB-S2 framing constants for the PL-frame sequencer.
package dvbs2_pkg;

  typedef enum logic [1:0] {
    SYM_HDR   = 2'd0,
    SYM_DATA  = 2'd1,
    SYM_PILOT = 2'd2,
    SYM_IDLE  = 2'd3
  } sym_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_PILOT
  } seq_state_t;

  localparam int HDR_LEN_STD      = 90;
  localparam int SLOT_LEN_STD     = 90;
  localparam int PILOT_LEN_STD    = 36;
  localparam int PILOT_PERIOD_STD = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pl_frame_sequencer_bit_repacker.sv
// Byte-to-symbol bit accumulator: MSB-aligned two-byte buffer with fill count,
// input backpressure, symbol pop, frame flush and a sticky underflow flag.
module bit_repacker #(
  parameter int DATA_W   = 8,
  parameter int SYM_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                pop_req,
  input  logic                flush,
  output logic [SYM_BITS-1:0] sym,
  output logic                underflow
);

  localparam int ACC_W  = 2 * DATA_W;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] FILL_BYTE = FILL_W'(DATA_W);
  localparam logic [FILL_W-1:0] FILL_SYM  = FILL_W'(SYM_BITS);

  logic [ACC_W-1:0]  acc, acc_n, base_acc;
  logic [FILL_W-1:0] fill, fill_n, base_fill;
  logic              avail, pop, accept;

  assign s_ready = !rst && (fill <= FILL_BYTE);
  assign avail   = (fill >= FILL_SYM);
  assign pop     = pop_req && avail;
  assign accept  = s_valid && s_ready;
  assign sym     = avail ? acc[ACC_W-1 -: SYM_BITS] : '0;

  // Flush or pop first, then append the accepted byte just below what remains.
  always_comb begin
    base_acc  = acc;
    base_fill = fill;
    if (flush) begin
      base_acc  = '0;
      base_fill = '0;
    end else if (pop) begin
      base_acc  = acc << SYM_BITS;
      base_fill = fill - FILL_SYM;
    end
    acc_n  = base_acc;
    fill_n = base_fill;
    if (accept) begin
      acc_n  = base_acc | ({s_data, {DATA_W{1'b0}}} >> base_fill);
      fill_n = base_fill + FILL_BYTE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      fill      <= '0;
      underflow <= 1'b0;
    end else begin
      acc  <= acc_n;
      fill <= fill_n;
      if (pop_req && !avail) underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/pl_frame_sequencer.sv
// DVB-S2 PL-frame symbol sequencer: PLHEADER, slotted payload, optional pilots.
// Define PILOT_INSERT_EN to build in pilot-block insertion.
module pl_frame_sequencer
  import dvbs2_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int SYM_BITS     = 3,
  parameter int HDR_LEN      = HDR_LEN_STD,
  parameter int SLOT_LEN     = SLOT_LEN_STD,
  parameter int N_SLOTS      = 240,
  parameter int PILOT_LEN    = PILOT_LEN_STD,
  parameter int PILOT_PERIOD = PILOT_PERIOD_STD,
  parameter int CLK_DIV      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [7:0]          hdr_idx,
  input  logic [SYM_BITS-1:0] hdr_sym,
  output logic [SYM_BITS-1:0] sym_out,
  output logic [1:0]          sym_type,
  output logic                sym_stb,
  output logic                frame_start,
  output logic                underflow
);

  localparam int BLK_MAX = max3(HDR_LEN, SLOT_LEN, PILOT_LEN);
  localparam int BLK_W   = (BLK_MAX > 1) ? $clog2(BLK_MAX) : 1;
  localparam int SLOT_W  = $clog2(N_SLOTS + 1);
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BLK_W-1:0]  HDR_LAST  = BLK_W'(HDR_LEN - 1);
  localparam logic [BLK_W-1:0]  SLOT_LAST = BLK_W'(SLOT_LEN - 1);
  localparam logic [SLOT_W-1:0] SLOTS_END = SLOT_W'(N_SLOTS);

`ifdef PILOT_INSERT_EN
  localparam int PER_W = (PILOT_PERIOD > 1) ? $clog2(PILOT_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(PILOT_PERIOD - 1);
  localparam logic [BLK_W-1:0] PILOT_LAST = BLK_W'(PILOT_LEN - 1);
  logic [PER_W-1:0] per_cnt, per_cnt_n;
`endif

  seq_state_t          state, state_n;
  logic [BLK_W-1:0]    blk, blk_n;
  logic [SLOT_W-1:0]   slot_cnt, slot_n, slot_done;
  logic [DIV_W-1:0]    div;
  logic                tick, pop_req, flush, fs_n;
  logic [SYM_BITS-1:0] data_sym, sym_n;
  logic [7:0]          hdr_idx_n;
  sym_type_t           type_n;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) div <= '0;
    else             div <= div + 1'b1;
  end

  bit_repacker #(
    .DATA_W   (DATA_W),
    .SYM_BITS (SYM_BITS)
  ) u_repacker (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .pop_req   (pop_req),
    .flush     (flush),
    .sym       (data_sym),
    .underflow (underflow)
  );

  // state_n/blk_n describe the symbol emitted on this strobe; slot_cnt holds
  // completed slots of the frame and survives pilot blocks.
  always_comb begin
    state_n   = state;
    blk_n     = blk;
    slot_n    = slot_cnt;
    slot_done = slot_cnt + 1'b1;
    flush     = 1'b0;
`ifdef PILOT_INSERT_EN
    per_cnt_n = per_cnt;
`endif
    if (tick) begin
      case (state)
        ST_IDLE: begin
          state_n = ST_HDR;
          blk_n   = '0;
        end
        ST_HDR: begin
          if (blk == HDR_LAST) begin
            state_n = ST_DATA;
            blk_n   = '0;
            slot_n  = '0;
`ifdef PILOT_INSERT_EN
            per_cnt_n = '0;
`endif
          end else begin
            blk_n = blk + 1'b1;
          end
        end
        ST_DATA: begin
          if (blk != SLOT_LAST) begin
            blk_n = blk + 1'b1;
          end else if (slot_done == SLOTS_END) begin
            state_n = ST_HDR;
            blk_n   = '0;
            slot_n  = '0;
            flush   = 1'b1;
`ifdef PILOT_INSERT_EN
          end else if (per_cnt == PER_LAST) begin
            state_n   = ST_PILOT;
            blk_n     = '0;
            slot_n    = slot_done;
            per_cnt_n = '0;
`endif
          end else begin
            blk_n  = '0;
            slot_n = slot_done;
`ifdef PILOT_INSERT_EN
            per_cnt_n = per_cnt + 1'b1;
`endif
          end
        end
`ifdef PILOT_INSERT_EN
        ST_PILOT: begin
          if (blk == PILOT_LAST) begin
            state_n = ST_DATA;
            blk_n   = '0;
          end else begin
            blk_n = blk + 1'b1;
          end
        end
`endif
        default: begin
          state_n = ST_IDLE;
          blk_n   = '0;
          slot_n  = '0;
        end
      endcase
    end
  end

  // Output values for the symbol selected above; only loaded on a strobe.
  always_comb begin
    type_n = SYM_IDLE;
    sym_n  = '0;
    case (state_n)
      ST_HDR:   begin type_n = SYM_HDR;  sym_n = hdr_sym;  end
      ST_DATA:  begin type_n = SYM_DATA; sym_n = data_sym; end
      ST_PILOT: type_n = SYM_PILOT;
      default:  type_n = SYM_IDLE;
    endcase
    pop_req   = tick && (state_n == ST_DATA);
    fs_n      = (state_n == ST_HDR) && (blk_n == '0);
    hdr_idx_n = ((state_n == ST_HDR) && (blk_n != HDR_LAST)) ? (8'(blk_n) + 8'd1) : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      blk      <= '0;
      slot_cnt <= '0;
`ifdef PILOT_INSERT_EN
      per_cnt  <= '0;
`endif
    end else begin
      state    <= state_n;
      blk      <= blk_n;
      slot_cnt <= slot_n;
`ifdef PILOT_INSERT_EN
      per_cnt  <= per_cnt_n;
`endif
    end
  end

  // hdr_idx leads the header symbol by one strobe so the external generator
  // has hdr_sym ready when the next header strobe samples it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_out     <= '0;
      sym_type    <= SYM_IDLE;
      sym_stb     <= 1'b0;
      frame_start <= 1'b0;
      hdr_idx     <= '0;
    end else begin
      sym_stb     <= tick;
      frame_start <= tick && fs_n;
      if (tick) begin
        sym_out  <= sym_n;
        sym_type <= type_n;
        hdr_idx  <= hdr_idx_n;
      end
    end
  end

endmodule
